median_window_3x3: RTL and testbench
====================================

Name: median_window_3x3

Overview:
- Upstream feeder for the median filter datapath.
- Accepts a raster-order 8-bit pixel stream, one pixel per valid cycle.
- Uses two line buffers and a 3x3 shift-register window to present each complete 3x3 neighbourhood to the downstream 3-input sorter network.
- Emits only fully-populated windows; border pixels produce no window.

Parameters:
- IMG_WIDTH, 8, pixels per line; minimum 3.
- IMG_HEIGHT, 8, lines per frame; minimum 3.
- DATA_W, 8, pixel width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_pixel carries a pixel this cycle.
- in_sof  input  1  qualified by in_valid; this pixel is (row 0, col 0) of a new frame.
- in_pixel  input  DATA_W  pixel value.
- out_valid  output  1  one-cycle strobe; out_win holds a new window.
- out_win  output  9*DATA_W  window, flattened; element w[r][c] at bits [DATA_W*(3*r+c) +: DATA_W].
- out_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low on rst_n.
- Reset values:
  - out_valid=0, out_frame_done=0, out_win=0.
  - Column counter=0, row counter=0, window registers=0.
  - Line buffer RAM contents are not reset; they are don't-care because no window reads stale rows (see border rule).
- Window orientation:
  - r=0 is the oldest row (y-2); c=0 is the oldest column (x-2).
  - w[1][1] is the centre pixel (y-1, x-1).
  - w[2][2] is the pixel just accepted.
- Per accepted pixel at (x, y), i.e. in_valid=1:
  - lb0[x] holds row y-1 and lb1[x] holds row y-2.
  - Update the line buffers as lb1[x] <= lb0[x] and lb0[x] <= in_pixel.
  - Shift each window row left by one column.
  - Load new column c=2 as {lb1[x], lb0[x], in_pixel} for rows 0, 1, 2.
  - Line buffer reads are same-address read-before-write within the cycle.
- Latency and output strobe:
  - out_valid is asserted the cycle after accepting the pixel with x>=2 and y>=2.
  - Fixed latency of 1 cycle.
  - out_win is registered and holds its value while out_valid=0.
- Emission counts:
  - No window is emitted for x<2 or y<2.
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are emitted per frame.
- Counters:
  - Column counter wraps from IMG_WIDTH-1 to 0 and increments the row counter.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1) both counters wrap to 0 and out_frame_done pulses the next cycle, coincident with the last out_valid.
- in_valid=0: all state holds. Gaps of any length anywhere in the frame, including mid-line, must not alter the output sequence.
- in_sof=1 with in_valid=1:
  - The pixel is treated as (0,0) regardless of counter state.
  - The counters are then (1,0).
  - A partially received frame is abandoned without an out_frame_done pulse.
- in_sof=1 with in_valid=0: ignored.
- No backpressure: downstream must accept a window every cycle.
- Mid-frame reset: the stream restarts at (0,0) and the first window appears only after two fresh lines plus 3 pixels.

Decomposition:
- Shared package constants:
  - DATA_W.
  - WIN_N=9.
  - An index function or constants for w[r][c] bit offsets, shared with the sorter network.
- Sub-module line_buffer_8bits: single-clock RAM of depth IMG_WIDTH, one read/one write port at the same address, read-before-write.
  - Instantiated twice, or once at 2*DATA_W width holding lb0 and lb1 together.
- Top level contains:
  - The counters.
  - The 3x3 window registers.
  - The output register stage.

Test Plan:
- Reset IMG_WIDTH=IMG_HEIGHT=4, stream pixels 0..15 back-to-back with in_sof on pixel 0.
  - Expect 4 windows, out_valid one cycle after pixels 10, 11, 14, 15.
  - First window w[0..2][0..2] = {0,1,2, 4,5,6, 8,9,10}.
  - Last window = {5,6,7, 9,10,11, 13,14,15}.
  - out_frame_done coincides with the 4th window.
- Same frame with in_valid deasserted for 3 cycles after every pixel: identical window values and count; out_valid still exactly 1 cycle after the qualifying pixel.
- Two frames back-to-back, second frame values 100..115:
  - Second frame's first window = {100,101,102,104,105,106,108,109,110}.
  - No window may mix data from the two frames.
- Assert in_sof at pixel 6 of a frame: counters resync; no out_frame_done for the abandoned frame; the next 16 pixels produce the 4 windows of a fresh frame.
- Pull rst_n low during pixel 9 (asynchronous, between clock edges): out_valid, out_win, out_frame_done drop to 0 immediately; the restarted frame yields the same windows as scenario 1.
- Default 8x8 frame with random pixels: 36 windows; each matches a software 3x3 extraction; w[1][1] equals the centre pixel.

Source files
------------

// File: rtl/median_window_3x3_pkg.sv
// median_window_3x3_pkg
//   Constants shared between the 3x3 window feeder and the downstream sorter
//   network: default pixel width, window element count, and the bit offset of
//   window element w[r][c] inside the flattened window bus.
//   No ports (package).
package median_window_3x3_pkg;

  localparam int DATA_W   = 8;
  localparam int WIN_ROWS = 3;
  localparam int WIN_COLS = 3;
  localparam int WIN_N    = WIN_ROWS * WIN_COLS;

  // Bit offset of w[r][c] in a flattened window of data_w-bit elements.
  // r=0 is the oldest row, c=0 the oldest column.
  function automatic int win_off(input int data_w, input int r, input int c);
    return data_w * (WIN_COLS * r + c);
  endfunction

endpackage

// File: rtl/median_window_3x3_line_buffer.sv
// line_buffer_8bits
//   Single-clock line memory, one entry per pixel column. Read and write share
//   one address; the read is combinational, so the read data in a cycle is the
//   value stored before that cycle's write (read-before-write).
//   Contents are not reset.
// Ports:
//   clk_i    rising-edge clock
//   we_i     write enable
//   addr_i   shared read/write address (column)
//   wdata_i  write data
//   rdata_o  read data (old contents at addr_i)
module line_buffer_8bits #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/median_window_3x3.sv
// median_window_3x3
//   Raster-order pixel stream in, fully populated 3x3 neighbourhoods out.
//   Two line buffers (packed into one memory word) supply the rows above the
//   incoming pixel; a small shift register supplies the previous two columns.
//   Border pixels (x<2 or y<2) produce no window.
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        in_pixel carries a pixel this cycle
//   in_sof          with in_valid: this pixel is (0,0) of a new frame
//   in_pixel        pixel value
//   out_valid       one-cycle strobe, out_win holds a new window
//   out_win         flattened window, w[r][c] at [DATA_W*(3*r+c) +: DATA_W]
//   out_frame_done  one-cycle pulse after the last pixel of a frame
module median_window_3x3 #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int DATA_W     = median_window_3x3_pkg::DATA_W
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  input  logic                                            in_sof,
  input  logic [DATA_W-1:0]                               in_pixel,
  output logic                                            out_valid,
  output logic [median_window_3x3_pkg::WIN_N*DATA_W-1:0]  out_win,
  output logic                                            out_frame_done
);

  import median_window_3x3_pkg::WIN_N;
  import median_window_3x3_pkg::WIN_COLS;
  import median_window_3x3_pkg::win_off;

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_WIN  = XW'(2);
  localparam logic [YW-1:0] Y_WIN  = YW'(2);

  logic [XW-1:0]           col_q, col_d, col_cur;
  logic [YW-1:0]           row_q, row_d, row_cur;
  logic [2*DATA_W-1:0]     lb_rd;
  logic [DATA_W-1:0]       lb0_rd, lb1_rd;
  // Only the two newest columns are stored; the newest column of the window
  // comes straight from the line buffers and the input pixel.
  logic [DATA_W-1:0]       hist_q [3][2];
  logic [DATA_W-1:0]       win_d  [3][3];
  logic [WIN_N*DATA_W-1:0] win_flat_d;
  logic [WIN_N*DATA_W-1:0] out_win_q;
  logic                    out_valid_q, out_frame_done_q;
  logic                    emit, last_pix;

  // A start-of-frame pixel is (0,0) whatever the counters say.
  assign col_cur  = in_sof ? '0 : col_q;
  assign row_cur  = in_sof ? '0 : row_q;
  assign emit     = in_valid && (col_cur >= X_WIN) && (row_cur >= Y_WIN);
  assign last_pix = in_valid && (col_cur == X_LAST) && (row_cur == Y_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_cur == X_LAST) begin
        col_d = '0;
        row_d = (row_cur == Y_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  // Word layout {lb1, lb0}: lb0 = row y-1, lb1 = row y-2 at this column.
  // Writing {lb0, pixel} ages both rows by one line in a single access.
  line_buffer_8bits #(
    .WIDTH (2 * DATA_W),
    .DEPTH (IMG_WIDTH)
  ) u_line_buffer (
    .clk_i   (clk),
    .we_i    (in_valid),
    .addr_i  (col_cur),
    .wdata_i ({lb0_rd, in_pixel}),
    .rdata_o (lb_rd)
  );

  assign lb0_rd = lb_rd[DATA_W-1:0];
  assign lb1_rd = lb_rd[2*DATA_W-1:DATA_W];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = hist_q[r][0];
      win_d[r][1] = hist_q[r][1];
    end
    win_d[0][2] = lb1_rd;
    win_d[1][2] = lb0_rd;
    win_d[2][2] = in_pixel;
  end

  for (genvar gi = 0; gi < WIN_N; gi++) begin : g_flat
    assign win_flat_d[win_off(DATA_W, gi / WIN_COLS, gi % WIN_COLS) +: DATA_W] =
      win_d[gi / WIN_COLS][gi % WIN_COLS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q            <= '0;
      row_q            <= '0;
      out_valid_q      <= 1'b0;
      out_frame_done_q <= 1'b0;
      out_win_q        <= '0;
      for (int r = 0; r < 3; r++) begin
        hist_q[r][0] <= '0;
        hist_q[r][1] <= '0;
      end
    end else begin
      out_valid_q      <= emit;
      out_frame_done_q <= last_pix;
      col_q            <= col_d;
      row_q            <= row_d;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          hist_q[r][0] <= win_d[r][1];
          hist_q[r][1] <= win_d[r][2];
        end
      end
      if (emit) begin
        out_win_q <= win_flat_d;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_win        = out_win_q;
  assign out_frame_done = out_frame_done_q;

endmodule

// File: tb/tb_median_window_3x3.sv
module tb_median_window_3x3;

  localparam int DW = 8;
  localparam int WW = 9 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_valid, a_sof, a_ov, a_done;
  logic [DW-1:0] a_pix;
  logic [WW-1:0] a_win;
  logic          b_valid, b_sof, b_ov, b_done;
  logic [DW-1:0] b_pix;
  logic [WW-1:0] b_win;

  median_window_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_sof(a_sof), .in_pixel(a_pix),
    .out_valid(a_ov), .out_win(a_win), .out_frame_done(a_done));

  median_window_3x3 #(.DATA_W(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_sof(b_sof), .in_pixel(b_pix),
    .out_valid(b_ov), .out_win(b_win), .out_frame_done(b_done));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the frame as a 2D image plus a raster cursor per DUT.
  int            wid [2] = '{4, 8};
  int            hgt [2] = '{4, 8};
  logic [DW-1:0] img [2][8][8];
  int            mx [2], my [2], px [2], py [2];
  logic          exp_v [2], exp_d [2];
  logic [WW-1:0] exp_w [2];
  logic          obs_v, obs_d;
  logic [WW-1:0] obs_w;

  function automatic logic [WW-1:0] pack9(input int e [9]);
    logic [WW-1:0] w;
    for (int k = 0; k < 9; k++) w[DW*k +: DW] = DW'(e[k]);
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mx[d] = 0; my[d] = 0; px[d] = 0; py[d] = 0;
      exp_v[d] = 1'b0; exp_d[d] = 1'b0; exp_w[d] = '0;
    end
  endtask

  // Drive one cycle on DUT d, advance the model, sample outputs 1 time unit after the edge.
  task automatic step(input int d, input logic v, input logic s, input logic [DW-1:0] p);
    if (d == 0) begin a_valid = v; a_sof = s; a_pix = p; end
    else        begin b_valid = v; b_sof = s; b_pix = p; end
    exp_v[d] = 1'b0;
    exp_d[d] = 1'b0;
    if (v) begin
      if (s) begin mx[d] = 0; my[d] = 0; end
      img[d][my[d]][mx[d]] = p;
      px[d] = mx[d]; py[d] = my[d];
      if (mx[d] >= 2 && my[d] >= 2) begin
        exp_v[d] = 1'b1;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_w[d][DW*(3*r+c) +: DW] = img[d][my[d]-2+r][mx[d]-2+c];
      end
      if (mx[d] == wid[d]-1 && my[d] == hgt[d]-1) exp_d[d] = 1'b1;
      if (mx[d] == wid[d]-1) begin
        mx[d] = 0;
        my[d] = (my[d] == hgt[d]-1) ? 0 : my[d] + 1;
      end else begin
        mx[d] = mx[d] + 1;
      end
    end
    @(posedge clk);
    #1;
    if (d == 0) begin obs_v = a_ov; obs_w = a_win; obs_d = a_done; end
    else        begin obs_v = b_ov; obs_w = b_win; obs_d = b_done; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 0; a_sof = 0; a_pix = '0;
    b_valid = 0; b_sof = 0; b_pix = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (a_ov !== 1'b0 || a_done !== 1'b0 || a_win !== '0) begin
      n_fail++;
      $display("FAIL reset_a valid=%b done=%b win=%h required all zero", a_ov, a_done, a_win);
    end
    n_tests++;
    if (b_ov !== 1'b0 || b_done !== 1'b0 || b_win !== '0) begin
      n_fail++;
      $display("FAIL reset_b valid=%b done=%b win=%h required all zero", b_ov, b_done, b_win);
    end
    #3 rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int nwin = 0, done_at = -1;
    logic [WW-1:0] first_w = '0, last_w = '0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) step(0, 1'b1, i == 0, DW'(i)); else step(0, 1'b0, 1'b0, '0);
      n_tests++;
      if (obs_v !== exp_v[0] || obs_w !== exp_w[0] || obs_d !== exp_d[0]) begin
        n_fail++;
        $display("FAIL basic i=%0d valid=%b/%b done=%b/%b win=%h/%h (got/exp)", i, obs_v, exp_v[0], obs_d, exp_d[0], obs_w, exp_w[0]);
      end
      if (obs_v) begin if (nwin == 0) first_w = obs_w; last_w = obs_w; nwin++; end
      if (obs_d) done_at = nwin;
    end
    n_tests++;
    if (nwin !== 4) begin n_fail++; $display("FAIL basic_count got=%0d exp=4", nwin); end
    n_tests++;
    if (first_w !== pack9('{0,1,2,4,5,6,8,9,10})) begin
      n_fail++; $display("FAIL basic_first got=%h exp=%h", first_w, pack9('{0,1,2,4,5,6,8,9,10}));
    end
    n_tests++;
    if (last_w !== pack9('{5,6,7,9,10,11,13,14,15})) begin
      n_fail++; $display("FAIL basic_last got=%h exp=%h", last_w, pack9('{5,6,7,9,10,11,13,14,15}));
    end
    n_tests++;
    if (done_at !== 4) begin n_fail++; $display("FAIL basic_done_window got=%0d exp=4", done_at); end
    $display("[TB] basic frame: %0d windows", nwin);
  endtask

  task automatic test_gaps();
    int nwin = 0;
    logic [WW-1:0] last_w = '0;
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < 4; g++) begin
        if (g == 0) step(0, 1'b1, i == 0, DW'(i)); else step(0, 1'b0, 1'b0, '0);
        n_tests++;
        if (obs_v !== exp_v[0] || obs_w !== exp_w[0] || obs_d !== exp_d[0]) begin
          n_fail++;
          $display("FAIL gaps i=%0d g=%0d valid=%b/%b done=%b/%b win=%h/%h (got/exp)", i, g, obs_v, exp_v[0], obs_d, exp_d[0], obs_w, exp_w[0]);
        end
        if (obs_v) begin nwin++; last_w = obs_w; end
      end
    end
    n_tests++;
    if (nwin !== 4 || last_w !== pack9('{5,6,7,9,10,11,13,14,15})) begin
      n_fail++; $display("FAIL gaps_summary count=%0d last=%h exp count=4", nwin, last_w);
    end
    $display("[TB] gapped frame: %0d windows", nwin);
  endtask

  task automatic test_back_to_back();
    int nwin = 0;
    logic [WW-1:0] second_first = '0;
    for (int i = 0; i < 32; i++) begin
      step(0, 1'b1, (i % 16) == 0, (i < 16) ? DW'(i) : DW'(100 + i - 16));
      n_tests++;
      if (obs_v !== exp_v[0] || obs_w !== exp_w[0] || obs_d !== exp_d[0]) begin
        n_fail++;
        $display("FAIL b2b i=%0d valid=%b/%b done=%b/%b win=%h/%h (got/exp)", i, obs_v, exp_v[0], obs_d, exp_d[0], obs_w, exp_w[0]);
      end
      if (obs_v) begin nwin++; if (nwin == 5) second_first = obs_w; end
    end
    step(0, 1'b0, 1'b0, '0);
    n_tests++;
    if (second_first !== pack9('{100,101,102,104,105,106,108,109,110})) begin
      n_fail++; $display("FAIL b2b_second_first got=%h exp=%h", second_first, pack9('{100,101,102,104,105,106,108,109,110}));
    end
    $display("[TB] back-to-back frames: %0d windows", nwin);
  endtask

  task automatic test_sof_resync();
    int nwin = 0, ndone = 0;
    for (int i = 0; i < 23; i++) begin
      if (i < 6)       step(0, 1'b1, i == 0, DW'($urandom_range(0, 255)));
      else if (i < 22) step(0, 1'b1, i == 6, DW'($urandom_range(0, 255)));
      else             step(0, 1'b0, 1'b0, '0);
      n_tests++;
      if (obs_v !== exp_v[0] || obs_w !== exp_w[0] || obs_d !== exp_d[0]) begin
        n_fail++;
        $display("FAIL sof_resync i=%0d valid=%b/%b done=%b/%b win=%h/%h (got/exp)", i, obs_v, exp_v[0], obs_d, exp_d[0], obs_w, exp_w[0]);
      end
      if (obs_v) nwin++;
      if (obs_d) ndone++;
    end
    n_tests++;
    if (nwin !== 4 || ndone !== 1) begin
      n_fail++; $display("FAIL sof_resync_counts windows=%0d done=%0d exp 4 and 1", nwin, ndone);
    end
    $display("[TB] sof resync: %0d windows, %0d done pulses", nwin, ndone);
  endtask

  task automatic test_async_reset();
    int nwin = 0, ndone = 0;
    for (int i = 0; i < 9; i++) step(0, 1'b1, i == 0, DW'(i));
    a_valid = 1'b1; a_sof = 1'b0; a_pix = DW'(9);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (a_ov !== 1'b0 || a_done !== 1'b0 || a_win !== '0) begin
      n_fail++; $display("FAIL async_reset valid=%b done=%b win=%h required all zero", a_ov, a_done, a_win);
    end
    a_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    // No in_sof: the counters must restart at (0,0) out of reset.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) step(0, 1'b1, 1'b0, DW'(i)); else step(0, 1'b0, 1'b0, '0);
      n_tests++;
      if (obs_v !== exp_v[0] || obs_w !== exp_w[0] || obs_d !== exp_d[0]) begin
        n_fail++;
        $display("FAIL after_reset i=%0d valid=%b/%b done=%b/%b win=%h/%h (got/exp)", i, obs_v, exp_v[0], obs_d, exp_d[0], obs_w, exp_w[0]);
      end
      if (obs_v) nwin++;
      if (obs_d) ndone++;
    end
    n_tests++;
    if (nwin !== 4 || ndone !== 1) begin
      n_fail++; $display("FAIL after_reset_counts windows=%0d done=%0d exp 4 and 1", nwin, ndone);
    end
    $display("[TB] async reset restart: %0d windows", nwin);
  endtask

  task automatic test_random_gaps();
    int nwin = 0;
    for (int i = 0; i < 16; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g <= gap; g++) begin
        // Idle cycles carry a random in_sof, which must be ignored.
        if (g == 0) step(0, 1'b1, i == 0, DW'($urandom_range(0, 255)));
        else        step(0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)));
        n_tests++;
        if (obs_v !== exp_v[0] || obs_w !== exp_w[0] || obs_d !== exp_d[0]) begin
          n_fail++;
          $display("FAIL rand_gaps i=%0d g=%0d valid=%b/%b done=%b/%b win=%h/%h (got/exp)", i, g, obs_v, exp_v[0], obs_d, exp_d[0], obs_w, exp_w[0]);
        end
        if (obs_v) nwin++;
      end
    end
    step(0, 1'b0, 1'b0, '0);
    n_tests++;
    if (nwin !== 4) begin n_fail++; $display("FAIL rand_gaps_count got=%0d exp=4", nwin); end
    $display("[TB] random-gap frame: %0d windows", nwin);
  endtask

  task automatic test_random_8x8();
    int nwin = 0, ndone = 0;
    for (int i = 0; i < 65; i++) begin
      if (i < 64) step(1, 1'b1, i == 0, DW'($urandom_range(0, 255)));
      else        step(1, 1'b0, 1'b0, '0);
      n_tests++;
      if (obs_v !== exp_v[1] || obs_w !== exp_w[1] || obs_d !== exp_d[1]) begin
        n_fail++;
        $display("FAIL rand8 i=%0d valid=%b/%b done=%b/%b win=%h/%h (got/exp)", i, obs_v, exp_v[1], obs_d, exp_d[1], obs_w, exp_w[1]);
      end
      if (obs_v && i < 64) begin
        nwin++;
        n_tests++;
        if (obs_w[4*DW +: DW] !== img[1][py[1]-1][px[1]-1]) begin
          n_fail++; $display("FAIL rand8_centre i=%0d got=%0d exp=%0d", i, obs_w[4*DW +: DW], img[1][py[1]-1][px[1]-1]);
        end
      end
      if (obs_d) ndone++;
      if ($urandom_range(0, 3) == 0) step(1, 1'b0, 1'b0, '0);
    end
    n_tests++;
    if (nwin !== 36 || ndone !== 1) begin
      n_fail++; $display("FAIL rand8_counts windows=%0d done=%0d exp 36 and 1", nwin, ndone);
    end
    $display("[TB] random 8x8 frame: %0d windows", nwin);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_sof_resync();
    test_async_reset();
    test_random_gaps();
    test_random_8x8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
